// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, shared-ALU and response signal bundle for alu_arbiter
interface alu_arbiter_if #(
    parameter int BW = 16
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic signed [BW-1:0] req0_a;
    logic signed [BW-1:0] req0_b;
    logic [3:0]           req0_opcode;
    logic                 req1_valid;
    logic                 req1_ready;
    logic signed [BW-1:0] req1_a;
    logic signed [BW-1:0] req1_b;
    logic [3:0]           req1_opcode;
    logic signed [BW-1:0] alu_in_a;
    logic signed [BW-1:0] alu_in_b;
    logic [3:0]           alu_opcode;
    logic signed [BW-1:0] alu_out;
    logic [2:0]           alu_flags;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic signed [BW-1:0] rsp_out;
    logic [2:0]           rsp_flags;
    logic [15:0]          perf_cnt0;
    logic [15:0]          perf_cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_opcode,
        input  req1_valid, req1_a, req1_b, req1_opcode,
        input  alu_out, alu_flags, rsp_ready,
        output req0_ready, req1_ready,
        output alu_in_a, alu_in_b, alu_opcode,
        output rsp_valid, rsp_id, rsp_out, rsp_flags,
        output perf_cnt0, perf_cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_opcode,
        output req1_valid, req1_a, req1_b, req1_opcode,
        output alu_out, alu_flags, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_in_a, alu_in_b, alu_opcode,
        input  rsp_valid, rsp_id, rsp_out, rsp_flags,
        input  perf_cnt0, perf_cnt1
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
// Optional per-requester completion counters are built when ALU_ARB_PERF_EN is defined.
module alu_arbiter #(
    parameter int BW = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               r_state;
    logic                 r_prio;
    logic                 r_id;
    logic signed [BW-1:0] r_a;
    logic signed [BW-1:0] r_b;
    logic [3:0]           r_op;
    logic signed [BW-1:0] r_rsp_out;
    logic [2:0]           r_rsp_flags;

    logic w_grant;
    logic w_accept;
    logic w_rsp_done;

    // r_prio names the requester that wins when both are valid
    assign w_grant    = (bus.req0_valid && bus.req1_valid) ? r_prio : bus.req1_valid;
    assign w_accept   = (r_state == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
    assign w_rsp_done = (r_state == RESP) && !rst && bus.rsp_ready;

    assign bus.req0_ready = w_accept && !w_grant;
    assign bus.req1_ready = w_accept && w_grant;
    assign bus.rsp_valid  = (r_state == RESP) && !rst;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_out    = r_rsp_out;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.alu_in_a   = r_a;
    assign bus.alu_in_b   = r_b;
    assign bus.alu_opcode = r_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_id        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_rsp_out   <= '0;
            r_rsp_flags <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_grant ? bus.req1_a : bus.req0_a;
                        r_b     <= w_grant ? bus.req1_b : bus.req0_b;
                        r_op    <= w_grant ? bus.req1_opcode : bus.req0_opcode;
                        r_id    <= w_grant;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_out   <= bus.alu_out;
                    r_rsp_flags <= bus.alu_flags;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (w_rsp_done) begin
                        r_prio  <= ~r_id;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic [15:0] r_perf0;
    logic [15:0] r_perf1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf0 <= '0;
            r_perf1 <= '0;
        end else if (w_rsp_done) begin
            if (!r_id && r_perf0 != 16'hFFFF) r_perf0 <= r_perf0 + 16'd1;
            if (r_id && r_perf1 != 16'hFFFF)  r_perf1 <= r_perf1 + 16'd1;
        end
    end

    assign bus.perf_cnt0 = r_perf0;
    assign bus.perf_cnt1 = r_perf1;
`else
    assign bus.perf_cnt0 = 16'h0000;
    assign bus.perf_cnt1 = 16'h0000;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU and arbiter model
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.BW(16)) bus ();

    alu_arbiter #(.BW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference ALU: returns {overflow, negative, zero, result}; unknown opcodes add the opcode to a
    function automatic logic [18:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        logic [15:0] r;
        logic        ov;
        ov = 1'b0;
        case (op)
            4'd0: begin r = a + b; ov = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd1: begin r = a - b; ov = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: r = a + {12'h000, op};
        endcase
        return {ov, r[15], (r == 16'h0000), r};
    endfunction

    always_comb {bus.alu_flags, bus.alu_out} = alu_f(bus.alu_in_a, bus.alu_in_b, bus.alu_opcode);

    bit          pv  [2];
    logic [15:0] pa  [2];
    logic [15:0] pb  [2];
    logic [3:0]  pop [2];
    int          prio;
    int          cnt [2];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        bus.req0_valid  = pv[0];
        bus.req0_a      = pa[0];
        bus.req0_b      = pb[0];
        bus.req0_opcode = pop[0];
        bus.req1_valid  = pv[1];
        bus.req1_a      = pa[1];
        bus.req1_b      = pb[1];
        bus.req1_opcode = pop[1];
    endtask

    task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        pv[r] = 1'b1; pa[r] = a; pb[r] = b; pop[r] = op;
    endtask

    function automatic int pick();
        if (pv[0] && pv[1]) return prio;
        return pv[1] ? 1 : 0;
    endfunction

    task automatic chk_perf();
`ifdef ALU_ARB_PERF_EN
        chk("perf_cnt0", bus.perf_cnt0, 16'(cnt[0]));
        chk("perf_cnt1", bus.perf_cnt1, 16'(cnt[1]));
`else
        chk("perf_cnt0", bus.perf_cnt0, 16'h0000);
        chk("perf_cnt1", bus.perf_cnt1, 16'h0000);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pv[0] = 1'b0; pv[1] = 1'b0;
        drive_reqs();
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        prio = 0; cnt[0] = 0; cnt[1] = 0;
    endtask

    // Entered and left at posedge+1; g is the requester the model expects to be granted
    task automatic run_txn(input int g, input logic [15:0] eo, input logic [2:0] ef, input int stall);
        logic [15:0] sa, sb;
        logic [3:0]  sop;
        sa = pa[g]; sb = pb[g]; sop = pop[g];
        drive_reqs(); #1;
        chk("grant_ready0", 16'(bus.req0_ready), 16'(g == 0));
        chk("grant_ready1", 16'(bus.req1_ready), 16'(g == 1));
        @(posedge clk); #1;
        pv[g] = 1'b0;
        drive_reqs(); #1;
        chk("exec_alu_a", bus.alu_in_a, sa);
        chk("exec_alu_b", bus.alu_in_b, sb);
        chk("exec_alu_op", 16'(bus.alu_opcode), 16'(sop));
        chk("exec_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("exec_readies", 16'(bus.req0_ready | bus.req1_ready), 16'd0);
        @(posedge clk); #1;
        for (int s = 0; s <= stall; s++) begin
            bus.rsp_ready = (s == stall);
            #1;
            chk("resp_valid", 16'(bus.rsp_valid), 16'd1);
            chk("resp_id", 16'(bus.rsp_id), 16'(g));
            chk("resp_out", bus.rsp_out, eo);
            chk("resp_flags", 16'(bus.rsp_flags), 16'(ef));
            chk("resp_readies", 16'(bus.req0_ready | bus.req1_ready), 16'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b0;
        chk("done_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        if (cnt[g] < 65535) cnt[g]++;
        prio = 1 - g;
        chk_perf();
    endtask

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [15:0] eo;
        logic [2:0]  ef;
        int          stall;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int          g;
        logic [15:0] eo;
        logic [2:0]  ef;

        tbl[0] = '{0, 16'd10,    16'd5,     4'd0,  16'd15,    3'b000, 0};
        tbl[1] = '{1, 16'd32000, 16'd10000, 4'd0,  16'hA410,  3'b110, 1};
        tbl[2] = '{0, 16'd100,   16'd100,   4'd1,  16'h0000,  3'b001, 5};
        tbl[3] = '{1, 16'hFFFF,  16'h0001,  4'd0,  16'h0000,  3'b001, 0};
        tbl[4] = '{0, 16'h8000,  16'h0001,  4'd1,  16'h7FFF,  3'b100, 2};
        tbl[5] = '{1, 16'h00F0,  16'h0FF0,  4'd2,  16'h00F0,  3'b000, 0};
        tbl[6] = '{0, 16'hFFFB,  16'h0000,  4'd15, 16'h000A,  3'b000, 1};
        tbl[7] = '{1, 16'h7FFF,  16'h0000,  4'd9,  16'h8008,  3'b010, 0};

        for (int r = 0; r < 2; r++) begin pv[r] = 1'b0; pa[r] = '0; pb[r] = '0; pop[r] = '0; end
        prio = 0; cnt[0] = 0; cnt[1] = 0;
        drive_reqs();
        bus.rsp_ready = 1'b0;

        // Readies and rsp_valid must stay low while rst is held, even with a valid request
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ready0", 16'(bus.req0_ready), 16'd0);
        chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        do_reset();
        #1;
        chk("reset_alu_a", bus.alu_in_a, 16'h0000);
        chk("reset_alu_b", bus.alu_in_b, 16'h0000);
        chk("reset_alu_op", 16'(bus.alu_opcode), 16'h0000);
        chk("reset_rsp_out", bus.rsp_out, 16'h0000);
        chk("reset_rsp_flags", 16'(bus.rsp_flags), 16'h0000);
        chk("reset_rsp_valid", 16'(bus.rsp_valid), 16'h0000);
        chk_perf();
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            set_req(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op);
            run_txn(pick(), tbl[i].eo, tbl[i].ef, tbl[i].stall);
        end

        // Both valid straight after reset: requester 0 first, then requester 1
        do_reset();
        set_req(0, 16'hFFFD, 16'hFFF9, 4'd0);
        set_req(1, 16'd100, 16'd100, 4'd1);
        run_txn(pick(), 16'hFFF6, 3'b010, 0);
        run_txn(pick(), 16'h0000, 3'b001, 0);

        // Reset during RESP drops the operation and restores requester 0 priority
        do_reset();
        set_req(0, 16'd1, 16'd2, 4'd0);
        run_txn(pick(), 16'd3, 3'b000, 0);
        set_req(1, 16'd7, 16'd8, 4'd0);
        drive_reqs(); #1;
        chk("inflight_ready1", 16'(bus.req1_ready), 16'd1);
        @(posedge clk); #1;
        pv[1] = 1'b0; drive_reqs();
        @(posedge clk); #1;
        chk("inflight_resp_valid", 16'(bus.rsp_valid), 16'd1);
        rst = 1'b1; #1;
        chk("inflight_rst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        prio = 0; cnt[0] = 0; cnt[1] = 0;
        chk("post_rst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk_perf();
        set_req(0, 16'd20, 16'd22, 4'd0);
        set_req(1, 16'd5, 16'd5, 4'd1);
        run_txn(pick(), 16'd42, 3'b000, 0);
        run_txn(pick(), 16'd0, 3'b001, 0);

        // Three requester-0 and two requester-1 completions
        do_reset();
        for (int k = 0; k < 5; k++) begin
            g = (k < 3) ? 0 : 1;
            set_req(g, 16'(k), 16'd1, 4'd0);
            run_txn(pick(), 16'(k + 1), 3'b000, k % 2);
        end
`ifdef ALU_ARB_PERF_EN
        chk("perf_total0", bus.perf_cnt0, 16'd3);
        chk("perf_total1", bus.perf_cnt1, 16'd2);
`else
        chk("perf_total0", bus.perf_cnt0, 16'd0);
        chk("perf_total1", bus.perf_cnt1, 16'd0);
`endif

        // Random traffic: pending requests persist until served or withdrawn
        do_reset();
        for (int i = 0; i < 60; i++) begin
            for (int r = 0; r < 2; r++)
                if (!pv[r] && $urandom_range(0, 1) == 1)
                    set_req(r, 16'($urandom), 16'($urandom), 4'($urandom));
            if (!pv[0] && !pv[1]) set_req(int'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 4'($urandom));
            g = pick();
            {ef, eo} = alu_f(pa[g], pb[g], pop[g]);
            run_txn(g, eo, ef, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) pv[1 - g] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: BW, 16, operand/result bitwidth of the shared ALU.
REQ-002 Ports, all sampled on rising clk; reset is synchronous and active-high:
  clk  input  1  clock
  rst  input  1  synchronous active-high reset
  req0_valid  input  1  requester 0 has an operation
  req0_ready  output  1  requester 0 operation accepted this cycle
  req0_a, req0_b  input  BW (signed)  requester 0 operands
  req0_opcode  input  4  requester 0 ALU opcode
  req1_valid, req1_ready, req1_a, req1_b, req1_opcode  same as requester 0, for requester 1
  alu_in_a, alu_in_b  output  BW (signed)  operands to shared ALU
  alu_opcode  output  4  opcode to shared ALU
  alu_out  input  BW (signed)  ALU result
  alu_flags  input  3  ALU flags {overflow, negative, zero}
  rsp_valid  output  1  response available
  rsp_ready  input  1  consumer accepts response
  rsp_id  output  1  requester that issued the response
  rsp_out  output  BW (signed)  registered ALU result
  rsp_flags  output  3  registered {overflow, negative, zero}
  perf_cnt0, perf_cnt1  output  16  completed-operation counts per requester

Function
REQ-003 The block SHALL implement FSM states IDLE, EXEC, RESP.
REQ-004 In IDLE, reqN_ready SHALL be combinationally high only for the granted requester N with reqN_valid high; both readies SHALL be low in EXEC and RESP.
REQ-005 Grant SHALL be round-robin: a lone valid requester wins; with both valid, the requester not served last wins; after reset requester 0 has priority.
REQ-006 On an accept edge (IDLE, granted valid), operands, opcode and id SHALL be latched and the FSM SHALL go to EXEC.
REQ-007 alu_in_a, alu_in_b, alu_opcode SHALL be driven from the latched registers at all times (zero after reset).
REQ-008 At the EXEC edge, alu_out and alu_flags SHALL be captured into rsp_out and rsp_flags and the FSM SHALL go to RESP.
REQ-009 rsp_valid SHALL be high exactly in RESP, i.e. first visible two cycles after the accept edge.
REQ-010 In RESP, rsp_id, rsp_out, rsp_flags SHALL remain stable until rsp_valid and rsp_ready are both high at an edge, then the FSM SHALL go to IDLE and last-served SHALL update to rsp_id.
REQ-011 No new request SHALL be accepted in the same cycle a response completes; throughput is at most one operation per 3 cycles.
REQ-012 Requests with valid deasserted before acceptance SHALL be dropped with no side effect; opcodes SHALL pass unmodified, including 8..15.
REQ-013 Operand and result values SHALL be passed unmodified (no sign extension or truncation beyond BW).

Reset
REQ-014 At a rst edge, the FSM SHALL enter IDLE, latched operands/opcode/id, rsp_out, rsp_flags SHALL clear to zero, priority SHALL return to requester 0, and perf counters SHALL clear.
REQ-015 rst asserted in EXEC or RESP SHALL discard the in-flight operation with no response and no counter increment.
REQ-016 While rst is high, both reqN_ready and rsp_valid SHALL be low.

Configuration
REQ-017 With macro ALU_ARB_PERF_EN defined, perf_cntN SHALL increment by 1 on each response handshake with rsp_id=N, saturating at 16'hFFFF.
REQ-018 Without ALU_ARB_PERF_EN, perf_cnt0 and perf_cnt1 SHALL be constant zero and no counter logic is built.

Verification
REQ-019 Only req0: a=10, b=5, opcode=0, rsp_ready=1 -> req0_ready high in the accept cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_out=15, rsp_flags=3'b000.
REQ-020 After reset both valid (req0: -3,-7,op 0; req1: 100,100,op 1) -> req0 served first (rsp_out=-10, flags=3'b010), then req1 (rsp_out=0, flags=3'b001).
REQ-021 req1: 32000+10000, op 0 -> rsp_id=1, rsp_out=-23536, rsp_flags[2]=1.
REQ-022 rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_out, rsp_flags stable; both readies low; completes on the first cycle rsp_ready=1.
REQ-023 rst asserted one cycle in RESP -> rsp_valid low next cycle, FSM in IDLE, requester 0 priority, no counter increment.
REQ-024 With ALU_ARB_PERF_EN defined, 3 req0 and 2 req1 completions -> perf_cnt0=3, perf_cnt1=2; without it both read 0.
